// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake plus the decode-facing IF/ID view.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
  logic [5:0]  op_d;
  logic [5:0]  funct_d;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr_d, pcplus4_d, valid_d, op_d, funct_d,
    input  imem_rdata, imem_valid, stall_d, redirect, redirect_pc
  );

  // Memory / decode / branch-resolution side
  modport slave (
    input  imem_req, imem_addr, instr_d, pcplus4_d, valid_d, op_d, funct_d,
    output imem_rdata, imem_valid, stall_d, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem request, registered IF/ID
// boundary with a one-entry skid buffer for decode stalls and redirect squash.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,  // active-low, asynchronous
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StRun, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Request is withdrawn only while a stalled word sits in the skid buffer
  always_comb begin
    bus.imem_req  = (state_q != StHold);
    bus.imem_addr = (state_q == StDrain) ? req_addr_q : pc_q;
  end

  // Decode-facing outputs straight from the IF/ID register
  always_comb begin
    bus.instr_d   = ifid_instr_q;
    bus.pcplus4_d = ifid_pc4_q;
    bus.valid_d   = ifid_valid_q;
    bus.op_d      = ifid_instr_q[31:26];
    bus.funct_d   = ifid_instr_q[5:0];
  end

  // Next-state: redirect beats stall beats normal flow
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    buf_instr_d  = buf_instr_q;
    buf_pc4_d    = buf_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    unique case (state_q)
      StRun: begin
        // Tracks the live request so a redirect can keep draining it
        req_addr_d = pc_q;
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
          if (!bus.imem_valid) state_d = StDrain;
        end else if (bus.imem_valid) begin
          pc_d = pc_plus4;
          if (bus.stall_d) begin
            buf_instr_d = bus.imem_rdata;
            buf_pc4_d   = pc_plus4;
            state_d     = StHold;
          end else begin
            ifid_instr_d = bus.imem_rdata;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
          end
        end else if (!bus.stall_d) begin
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
        end
      end
      StHold: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = StRun;
        end else if (!bus.stall_d) begin
          ifid_instr_d = buf_instr_q;
          ifid_pc4_d   = buf_pc4_q;
          ifid_valid_d = 1'b1;
          state_d      = StRun;
        end
      end
      StDrain: begin
        // Stale response is swallowed; only the PC follows further redirects
        if (bus.redirect)   pc_d    = bus.redirect_pc;
        if (bus.imem_valid) state_d = StRun;
        if (!bus.stall_d) begin
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
        end
      end
      default: state_d = StRun;
    endcase

    // Squash IF/ID on any redirect, stalled or not
    if (bus.redirect) begin
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
    end
  end

  // State, PC, skid buffer and IF/ID registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StRun;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      buf_instr_q  <= '0;
      buf_pc4_q    <= '0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc4_q    <= buf_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through the fetch scenarios, then random
// stall/redirect/latency traffic checked against a program-order stream model.
module tb_fetch_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Behavioural memory: word = addr ^ xmask, answers after 'waits' wait cycles
  int unsigned waits       = 0;
  int unsigned wcnt;
  logic        force_valid = 1'b0;
  logic [31:0] xmask       = 32'h0;

  assign bus.imem_valid = force_valid || (bus.imem_req && (wcnt >= waits));
  assign bus.imem_rdata = force_valid ? 32'hBAD0_BAD0 : (bus.imem_addr ^ xmask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               wcnt <= 0;
    else if (!bus.imem_req || bus.imem_valid) wcnt <= 0;
    else                                      wcnt <= wcnt + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc, e, rpc, r;
    logic [31:0] p_instr, p_pc4, p_addr, p_rpc;
    logic        p_valid, p_req, p_ivalid, p_redir, p_stall;
    int          idle;

    bus.stall_d     = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    // Reset state
    tick();
    chk("rst_instr", bus.instr_d, 32'h0);
    chk("rst_pc4",   bus.pcplus4_d, 32'h0);
    chk("rst_valid", 32'(bus.valid_d), 32'h0);
    chk("rst_req",   32'(bus.imem_req), 32'h1);
    chk("rst_addr",  bus.imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait memory: one instruction per cycle
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("zw_instr", bus.instr_d, 32'(k * 4));
      chk("zw_pc4",   bus.pcplus4_d, 32'(k * 4 + 4));
      chk("zw_valid", 32'(bus.valid_d), 32'h1);
    end

    // Two wait states from a fresh reset
    waits = 2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("w2_addr0", bus.imem_addr, 32'h0);
    chk("w2_ivld0", 32'(bus.imem_valid), 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("w2_bub_valid", 32'(bus.valid_d), 32'h0);
      chk("w2_bub_instr", bus.instr_d, 32'h0);
      chk("w2_addr_hold", bus.imem_addr, 32'h0);
    end
    tick();
    chk("w2_i0_instr", bus.instr_d, 32'h0);
    chk("w2_i0_valid", 32'(bus.valid_d), 32'h1);
    chk("w2_i0_pc4",   bus.pcplus4_d, 32'h4);
    tick();
    chk("w2_b1", 32'(bus.valid_d), 32'h0);
    tick();
    chk("w2_b2", 32'(bus.valid_d), 32'h0);
    tick();
    chk("w2_i1_instr", bus.instr_d, 32'h4);
    chk("w2_i1_pc4",   bus.pcplus4_d, 32'h8);
    chk("w2_i1_valid", 32'(bus.valid_d), 32'h1);

    // Stall for three cycles while word @8 returns
    waits       = 0;
    bus.stall_d = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_hold_instr", bus.instr_d, 32'h4);
      chk("st_hold_valid", 32'(bus.valid_d), 32'h1);
      chk("st_req_low",    32'(bus.imem_req), 32'h0);
    end
    bus.stall_d = 1'b0;
    tick();
    chk("st_rel_instr", bus.instr_d, 32'h8);
    chk("st_rel_pc4",   bus.pcplus4_d, 32'hC);
    chk("st_rel_addr",  bus.imem_addr, 32'hC);
    chk("st_rel_req",   32'(bus.imem_req), 32'h1);

    // Redirect to 0x100 while a 3-wait request @C is outstanding
    waits           = 3;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rd_valid_lo", 32'(bus.valid_d), 32'h0);
      chk("rd_addr_c",   bus.imem_addr, 32'hC);
      tick();
    end
    chk("rd_valid_lo2", 32'(bus.valid_d), 32'h0);
    chk("rd_new_addr",  bus.imem_addr, 32'h100);
    waits = 0;
    tick();
    chk("rd_instr", bus.instr_d, 32'h100);
    chk("rd_pc4",   bus.pcplus4_d, 32'h104);
    chk("rd_valid", 32'(bus.valid_d), 32'h1);

    // Redirect together with stall while holding a buffered word
    bus.stall_d = 1'b1;
    tick();
    chk("rs_hold_instr", bus.instr_d, 32'h100);
    chk("rs_req_low",    32'(bus.imem_req), 32'h0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    tick();
    chk("rs_valid", 32'(bus.valid_d), 32'h0);
    chk("rs_instr", bus.instr_d, 32'h0);
    chk("rs_pc4",   bus.pcplus4_d, 32'h104);
    chk("rs_addr",  bus.imem_addr, 32'h200);
    bus.redirect = 1'b0;
    bus.stall_d  = 1'b0;
    tick();
    chk("rs_new_instr", bus.instr_d, 32'h200);
    chk("rs_new_pc4",   bus.pcplus4_d, 32'h204);

    // Async reset in the middle of a drain, with a late response during reset
    waits           = 3;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    tick();
    bus.redirect = 1'b0;
    chk("dr_addr", bus.imem_addr, 32'h204);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_instr", bus.instr_d, 32'h0);
    chk("ar_pc4",   bus.pcplus4_d, 32'h0);
    chk("ar_valid", 32'(bus.valid_d), 32'h0);
    chk("ar_req",   32'(bus.imem_req), 32'h1);
    chk("ar_addr",  bus.imem_addr, 32'h0);
    force_valid = 1'b1;
    tick();
    chk("ar_late_valid", 32'(bus.valid_d), 32'h0);
    chk("ar_late_instr", bus.instr_d, 32'h0);
    @(negedge clk);
    force_valid = 1'b0;
    waits       = 0;
    rst_n       = 1'b1;
    tick();
    chk("ar_i0_instr", bus.instr_d, 32'h0);
    chk("ar_i0_pc4",   bus.pcplus4_d, 32'h4);
    chk("ar_i0_valid", 32'(bus.valid_d), 32'h1);
    tick();
    chk("ar_i1_instr", bus.instr_d, 32'h4);

    // Random traffic against a program-order stream model
    xmask  = 32'h5A5A_C3C3;
    exp_pc = 32'h0;
    idle   = 0;
    for (int i = 0; i < 1500; i++) begin
      r               = $urandom;
      rpc             = $urandom;
      rpc[1:0]        = 2'b00;
      if (r[8:6] == 3'd0) rpc = 32'hFFFF_FFF0;
      bus.redirect    = (i == 0) || (r[3:0] == 4'd0);
      bus.stall_d     = (r[5:4] == 2'd0);
      bus.redirect_pc = rpc;
      @(negedge clk);
      p_instr  = bus.instr_d;
      p_pc4    = bus.pcplus4_d;
      p_valid  = bus.valid_d;
      p_req    = bus.imem_req;
      p_addr   = bus.imem_addr;
      p_ivalid = bus.imem_valid;
      p_redir  = bus.redirect;
      p_stall  = bus.stall_d;
      p_rpc    = bus.redirect_pc;
      tick();
      if (p_redir) begin
        chk("rnd_redir_valid", 32'(bus.valid_d), 32'h0);
        chk("rnd_redir_instr", bus.instr_d, 32'h0);
        chk("rnd_redir_pc4",   bus.pcplus4_d, p_pc4);
        exp_pc = p_rpc;
        idle   = 0;
      end else if (p_stall) begin
        chk("rnd_stall_instr", bus.instr_d, p_instr);
        chk("rnd_stall_pc4",   bus.pcplus4_d, p_pc4);
        chk("rnd_stall_valid", 32'(bus.valid_d), 32'(p_valid));
        idle++;
      end else if (bus.valid_d) begin
        e = exp_pc ^ xmask;
        chk("rnd_instr", bus.instr_d, e);
        chk("rnd_pc4",   bus.pcplus4_d, exp_pc + 32'd4);
        chk("rnd_op",    32'(bus.op_d), 32'(e[31:26]));
        chk("rnd_funct", 32'(bus.funct_d), 32'(e[5:0]));
        exp_pc = exp_pc + 32'd4;
        idle   = 0;
      end else begin
        chk("rnd_bub_instr", bus.instr_d, 32'h0);
        chk("rnd_bub_pc4",   bus.pcplus4_d, p_pc4);
        idle++;
      end
      if (p_req && !p_ivalid) begin
        chk("rnd_req_held",  32'(bus.imem_req), 32'h1);
        chk("rnd_addr_held", bus.imem_addr, p_addr);
      end
      chk("rnd_liveness", 32'(idle > 40), 32'h0);
      if (p_ivalid) waits = $urandom_range(0, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
